// File: rtl/weight_load_ctrl_pkg.sv
// Shared types and constants for the kernel weight loader.
package weight_load_ctrl_pkg;

  // Kernel shape selector; code 3 is reserved and rejected at start.
  typedef enum logic [1:0] {
    WMODE_5X5 = 2'd0,
    WMODE_4X4 = 2'd1,
    WMODE_4X2 = 2'd2,
    WMODE_ILL = 2'd3
  } wmode_e;

  // Weight counts per kernel shape (bias word follows the last weight).
  localparam int unsigned N_5X5 = 25;
  localparam int unsigned N_4X4 = 16;
  localparam int unsigned N_4X2 = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_W  = 3'd1,
    ST_RD_B  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Index of the last weight for a shape; the issue counter compares against it.
  function automatic logic [4:0] wmode_last(wmode_e m);
    case (m)
      WMODE_5X5: wmode_last = 5'(N_5X5 - 1);
      WMODE_4X4: wmode_last = 5'(N_4X4 - 1);
      default:   wmode_last = 5'(N_4X2 - 1);
    endcase
  endfunction

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Weight-memory read bus: request/address out, grant/data back.
interface weight_load_ctrl_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic [7:0]  mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_gnt, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_gnt, output mem_rdata);
endinterface

// File: rtl/weight_load_ctrl.sv
// Kernel weight loader: streams N weights plus one bias from weight memory
// to the weight buffer, one read per cycle while granted.
module weight_load_ctrl
  import weight_load_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_mode,
  input  logic [15:0] i_base,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_cfg_err,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic [7:0]  i_mem_rdata,
  output logic        o_weight_new,
  output logic        o_weight_new_16,
  output logic        o_weight_new_8,
  output logic [7:0]  o_weight,
  output logic        o_bias_new,
  output logic [7:0]  o_bias
);

  state_e      state_q, state_d;
  wmode_e      mode_q, mode_d;
  logic [4:0]  issue_cnt_q, issue_cnt_d;
  // Read accepted last edge; its data is on i_mem_rdata this cycle.
  logic        pend_q, pend_d;
  logic        pend_bias_q, pend_bias_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cfg_err_q, cfg_err_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        wnew_q, wnew_d;
  logic        wnew16_q, wnew16_d;
  logic        wnew8_q, wnew8_d;
  logic [7:0]  weight_q, weight_d;
  logic        bias_new_q, bias_new_d;
  logic [7:0]  bias_q, bias_d;

  logic        accept;
  assign accept = mem_req_q & i_mem_gnt;

  // Next-state and registered-output computation for the load sequence.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    issue_cnt_d = issue_cnt_q;
    busy_d      = busy_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    weight_d    = weight_q;
    bias_d      = bias_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    wnew_d      = 1'b0;
    wnew16_d    = 1'b0;
    wnew8_d     = 1'b0;
    bias_new_d  = 1'b0;
    pend_d      = accept;
    pend_bias_d = accept && (state_q == ST_RD_B);

    // Capture returning data; the bias is always the last read of a load.
    if (pend_q) begin
      if (pend_bias_q) begin
        bias_new_d = 1'b1;
        bias_d     = i_mem_rdata;
      end else begin
        weight_d = i_mem_rdata;
        case (mode_q)
          WMODE_5X5: wnew_d   = 1'b1;
          WMODE_4X4: wnew16_d = 1'b1;
          default:   wnew8_d  = 1'b1;
        endcase
      end
    end

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        // busy_q is still high during the o_done cycle, so a start there is dropped.
        if (i_start && !busy_q) begin
          if (wmode_e'(i_mode) == WMODE_ILL) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d     = ST_RD_W;
            mode_d      = wmode_e'(i_mode);
            issue_cnt_d = 5'd0;
            busy_d      = 1'b1;
            mem_req_d   = 1'b1;
            mem_addr_d  = i_base;
          end
        end
      end
      ST_RD_W: begin
        if (accept) begin
          // base+N for the bias is simply the next address after the last weight.
          mem_addr_d  = mem_addr_q + 16'd1;
          issue_cnt_d = issue_cnt_q + 5'd1;
          if (issue_cnt_q == wmode_last(mode_q)) state_d = ST_RD_B;
        end
      end
      ST_RD_B: begin
        if (accept) begin
          mem_req_d = 1'b0;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pend_q && pend_bias_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any load in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= WMODE_5X5;
      issue_cnt_q <= 5'd0;
      pend_q      <= 1'b0;
      pend_bias_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 16'd0;
      wnew_q      <= 1'b0;
      wnew16_q    <= 1'b0;
      wnew8_q     <= 1'b0;
      weight_q    <= 8'd0;
      bias_new_q  <= 1'b0;
      bias_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      issue_cnt_q <= issue_cnt_d;
      pend_q      <= pend_d;
      pend_bias_q <= pend_bias_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      wnew_q      <= wnew_d;
      wnew16_q    <= wnew16_d;
      wnew8_q     <= wnew8_d;
      weight_q    <= weight_d;
      bias_new_q  <= bias_new_d;
      bias_q      <= bias_d;
    end
  end

  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_cfg_err       = cfg_err_q;
  assign o_mem_req       = mem_req_q;
  assign o_mem_addr      = mem_addr_q;
  assign o_weight_new    = wnew_q;
  assign o_weight_new_16 = wnew16_q;
  assign o_weight_new_8  = wnew8_q;
  assign o_weight        = weight_q;
  assign o_bias_new      = bias_new_q;
  assign o_bias          = bias_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl: stimulus pushes expected events,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_weight_load_ctrl;
  import weight_load_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [1:0]  i_mode;
  logic [15:0] i_base;
  logic        o_busy, o_done, o_cfg_err;
  logic        o_weight_new, o_weight_new_16, o_weight_new_8, o_bias_new;
  logic [7:0]  o_weight, o_bias;

  weight_load_ctrl_if mbus ();

  weight_load_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_start(i_start), .i_mode(i_mode), .i_base(i_base),
    .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err),
    .o_mem_req(mbus.mem_req), .o_mem_addr(mbus.mem_addr),
    .i_mem_gnt(mbus.mem_gnt), .i_mem_rdata(mbus.mem_rdata),
    .o_weight_new(o_weight_new), .o_weight_new_16(o_weight_new_16),
    .o_weight_new_8(o_weight_new_8), .o_weight(o_weight),
    .o_bias_new(o_bias_new), .o_bias(o_bias)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] K_W25 = 3'd1, K_W16 = 3'd2, K_W8 = 3'd3,
                         K_BIAS = 3'd4, K_DONE = 3'd5, K_ERR = 3'd6;

  typedef struct { logic [2:0] kind; logic [7:0] data; } ev_t;

  ev_t         evq[$];
  logic [15:0] addrq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int wstb_cnt = 0;
  bit gnt_toggle = 0;
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;
  logic [15:0] prev_addr = 16'd0;

  // Memory contents: a fixed byte pattern derived from the address.
  function automatic logic [7:0] mem_byte(logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Memory model: data for an accepted read appears the following cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mbus.mem_req && mbus.mem_gnt) mbus.mem_rdata <= mem_byte(mbus.mem_addr);
  end

  // Grant driver: tied high or alternating, changed just after each edge.
  initial begin
    mbus.mem_gnt   = 1'b1;
    mbus.mem_rdata = 8'd0;
    forever begin
      @(posedge clk); #1;
      mbus.mem_gnt = gnt_toggle ? ~mbus.mem_gnt : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic see_ev(input logic [2:0] kind, input logic [7:0] data);
    ev_t e;
    if (evq.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none", kind, data);
    end else begin
      e = evq.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      if (kind != K_DONE && kind != K_ERR) chk("event_data", 32'(data), 32'(e.data));
    end
  endtask

  // Monitor: compare strobes, pulses and accepted addresses against the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      automatic int nstb = int'(o_weight_new) + int'(o_weight_new_16) +
                           int'(o_weight_new_8) + int'(o_bias_new);
      if (nstb != 0) chk("one_strobe", 32'(nstb), 32'd1);
      if (o_weight_new)    begin see_ev(K_W25, o_weight); wstb_cnt++; end
      if (o_weight_new_16) begin see_ev(K_W16, o_weight); wstb_cnt++; end
      if (o_weight_new_8)  begin see_ev(K_W8,  o_weight); wstb_cnt++; end
      if (o_bias_new)      see_ev(K_BIAS, o_bias);
      if (o_done)    begin see_ev(K_DONE, 8'd0); done_cyc = cyc; done_cnt++; end
      if (o_cfg_err) see_ev(K_ERR, 8'd0);
      if (prev_req && !prev_gnt)
        chk("req_hold", {15'd0, mbus.mem_req, mbus.mem_addr}, {15'd0, 1'b1, prev_addr});
      if (mbus.mem_req && mbus.mem_gnt) begin
        if (addrq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_read: got addr %0h expected none", mbus.mem_addr);
        end else begin
          chk("read_addr", 32'(mbus.mem_addr), 32'(addrq.pop_front()));
        end
      end
      prev_req  = mbus.mem_req;
      prev_gnt  = mbus.mem_gnt;
      prev_addr = mbus.mem_addr;
    end
  end

  task automatic expect_load(input logic [1:0] mode, input logic [15:0] base);
    int n;
    logic [2:0] k;
    n = (mode == 2'd0) ? 25 : (mode == 2'd1) ? 16 : 8;
    k = (mode == 2'd0) ? K_W25 : (mode == 2'd1) ? K_W16 : K_W8;
    for (int i = 0; i < n; i++) begin
      evq.push_back('{kind: k, data: mem_byte(base + 16'(i))});
      addrq.push_back(base + 16'(i));
    end
    evq.push_back('{kind: K_BIAS, data: mem_byte(base + 16'(n))});
    addrq.push_back(base + 16'(n));
    evq.push_back('{kind: K_DONE, data: 8'd0});
  endtask

  task automatic pulse_start(input logic [1:0] mode, input logic [15:0] base);
    @(posedge clk); #1;
    i_start = 1'b1; i_mode = mode; i_base = base;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(evq.size() == 0 && !o_busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_finished"}, 32'(n < 300), 32'd1);
    chk({name, "_reads_left"}, 32'(addrq.size()), 32'd0);
  endtask

  initial begin
    int t0, n;
    rst_n = 1'b0; i_start = 1'b0; i_mode = 2'd0; i_base = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {o_busy, o_done, o_cfg_err, mbus.mem_req, mbus.mem_addr, o_weight_new,
         o_weight_new_16, o_weight_new_8, o_weight, o_bias_new, o_bias}, 32'd0);
    rst_n = 1'b1;

    // Mode 0, base 0x0100, grant tied high: also check start-to-done latency.
    expect_load(2'd0, 16'h0100);
    @(posedge clk); #1;
    i_start = 1'b1; i_mode = 2'd0; i_base = 16'h0100;
    t0 = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_idle("mode0");
    chk("done_latency", 32'(done_cyc - t0), 32'd29);

    // Mode 2 with toggling grant; monitor checks address holds while grant is low.
    gnt_toggle = 1;
    expect_load(2'd2, 16'h0040);
    pulse_start(2'd2, 16'h0040);
    wait_idle("mode2_toggle");
    gnt_toggle = 0;

    // Illegal mode: one error pulse, no request, never busy.
    evq.push_back('{kind: K_ERR, data: 8'd0});
    pulse_start(2'd3, 16'h1234);
    repeat (5) begin
      @(negedge clk);
      chk("err_stays_idle", {30'd0, o_busy, mbus.mem_req}, 32'd0);
    end
    chk("err_pulse_seen", 32'(evq.size()), 32'd0);

    // Mode 1 across the top of the address space.
    expect_load(2'd1, 16'hFFF8);
    pulse_start(2'd1, 16'hFFF8);
    wait_idle("mode1_wrap");

    // Reset after ten strobes, then a clean full load.
    wstb_cnt = 0;
    done_cnt = 0;
    expect_load(2'd0, 16'h0200);
    pulse_start(2'd0, 16'h0200);
    n = 0;
    while (wstb_cnt < 10 && n < 100) begin @(posedge clk); n++; end
    chk("abort_reached_10", 32'(n < 100), 32'd1);
    #1;
    rst_n = 1'b0;
    evq.delete();
    addrq.delete();
    #1;
    chk("async_reset_outputs",
        {o_busy, o_done, o_cfg_err, mbus.mem_req, o_weight_new, o_weight_new_16,
         o_weight_new_8, o_bias_new}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_load(2'd0, 16'h0300);
    pulse_start(2'd0, 16'h0300);
    wait_idle("restart");
    chk("restart_one_done", 32'(done_cnt), 32'd1);

    // Starts while busy are ignored (no error, no second load).
    done_cnt = 0;
    expect_load(2'd2, 16'h0010);
    pulse_start(2'd2, 16'h0010);
    repeat (2) @(posedge clk);
    pulse_start(2'd3, 16'h0000);
    repeat (2) @(posedge clk);
    pulse_start(2'd0, 16'h5555);
    wait_idle("busy_start");
    repeat (5) @(posedge clk);
    chk("busy_one_done", 32'(done_cnt), 32'd1);
    chk("busy_no_extra", 32'(evq.size() + addrq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
